vp_fp_mul_pipe: RTL and testbench



---
 rtl/vp_fp_mul_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vp_fp_mul_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// vp_fp_mul_pipe -- pipelined variable-precision floating-point multiplier.
//
// Multiplies two operands in a generic 1/EXP_W/MAN_W floating-point format.
// The default 8/7 split is bfloat16-compatible. A run-time precision mode can
// drop mantissa LSBs. The result is rounded to nearest-even, and exception
// flags are raised. The data path sits behind an elastic valid/ready pipeline.
//
// Stages:
//   S1  unpack, classify, truncate per prec_mode, sign and exponent sum
//   S2  hidden-bit mantissa multiply
//   S3  normalise, round, exception select, pack (this is the output register)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active-low
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (combinational from out_ready)
//   a, b       operands {sign, exponent, mantissa}
//   prec_mode  0 full, 1 drop TRUNC1 LSBs, 2 drop TRUNC2 LSBs, 3 same as 0
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   product    packed result
//   flags      {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module vp_fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter int TRUNC1 = 2,
    parameter int TRUNC2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           prec_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] product,
    output logic [3:0]           flags
);

    localparam int EW = EXP_W + 2;      // signed exponent working width
    localparam int MW = MAN_W + 1;      // mantissa with hidden bit
    localparam int PW = 2 * MAN_W + 2;  // full mantissa product width

    localparam logic [EXP_W-1:0]     EXP_ONES   = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]     EXP_ZERO   = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0]     MAN_ZERO   = {MAN_W{1'b0}};
    localparam logic [MAN_W-1:0]     MAN_QNAN   = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [MAN_W-1:0]     MASK_FULL  = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0]     MASK_T1    = MASK_FULL << TRUNC1;
    localparam logic [MAN_W-1:0]     MASK_T2    = MASK_FULL << TRUNC2;
    localparam logic signed [EW-1:0] BIAS       = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_INF_S  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO_S = {EW{1'b0}};

    // ------------------------------------------------------------------
    // Handshake: each stage loads when empty or when its contents move on
    // ------------------------------------------------------------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_s1_load, w_s2_load, w_s3_load;

    assign w_s3_load = !r3_valid || out_ready;
    assign w_s2_load = !r2_valid || w_s3_load;
    assign w_s1_load = !r1_valid || w_s2_load;
    assign in_ready  = w_s1_load;
    assign out_valid = r3_valid;

    // ------------------------------------------------------------------
    // S1 combinational: unpack and classify
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]     w_ea, w_eb;
    logic [MAN_W-1:0]     w_ma, w_mb, w_mask;
    logic                 w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic signed [EW-1:0] w_esum;

    assign w_ea = a[EXP_W+MAN_W-1:MAN_W];
    assign w_eb = b[EXP_W+MAN_W-1:MAN_W];
    assign w_ma = a[MAN_W-1:0];
    assign w_mb = b[MAN_W-1:0];

    // Subnormals (exp == 0) are flushed, so exponent alone decides zero.
    // Inf/NaN are classified on the untruncated mantissa so that a NaN
    // payload living only in the dropped LSBs is still a NaN.
    assign w_zero_a = (w_ea == EXP_ZERO);
    assign w_zero_b = (w_eb == EXP_ZERO);
    assign w_inf_a  = (w_ea == EXP_ONES) && (w_ma == MAN_ZERO);
    assign w_inf_b  = (w_eb == EXP_ONES) && (w_mb == MAN_ZERO);
    assign w_nan_a  = (w_ea == EXP_ONES) && (w_ma != MAN_ZERO);
    assign w_nan_b  = (w_eb == EXP_ONES) && (w_mb != MAN_ZERO);

    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    // Precision mode selects the mantissa keep-mask
    always_comb begin
        w_mask = MASK_FULL;
        case (prec_mode)
            2'd1:    w_mask = MASK_T1;
            2'd2:    w_mask = MASK_T2;
            default: w_mask = MASK_FULL;
        endcase
    end

    // ------------------------------------------------------------------
    // S1 register
    // ------------------------------------------------------------------
    logic                 r1_sign, r1_nan, r1_inf, r1_zero;
    logic signed [EW-1:0] r1_exp;
    logic [MW-1:0]        r1_ma, r1_mb;

    // Stage 1: capture class, sign, exponent sum and truncated mantissas
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_nan   <= 1'b0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_exp   <= EXP_ZERO_S;
            r1_ma    <= {MW{1'b0}};
            r1_mb    <= {MW{1'b0}};
        end else if (w_s1_load) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_sign <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                r1_nan  <= w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b);
                r1_inf  <= w_inf_a || w_inf_b;
                r1_zero <= w_zero_a || w_zero_b;
                r1_exp  <= w_esum;
                r1_ma   <= {1'b1, w_ma & w_mask};
                r1_mb   <= {1'b1, w_mb & w_mask};
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 register: mantissa product
    // ------------------------------------------------------------------
    logic                 r2_sign, r2_nan, r2_inf, r2_zero;
    logic signed [EW-1:0] r2_exp;
    logic [PW-1:0]        r2_prod;

    // Stage 2: multiply hidden-bit mantissas, forward the rest unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_nan   <= 1'b0;
            r2_inf   <= 1'b0;
            r2_zero  <= 1'b0;
            r2_exp   <= EXP_ZERO_S;
            r2_prod  <= {PW{1'b0}};
        end else if (w_s2_load) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign <= r1_sign;
                r2_nan  <= r1_nan;
                r2_inf  <= r1_inf;
                r2_zero <= r1_zero;
                r2_exp  <= r1_exp;
                r2_prod <= {{MW{1'b0}}, r1_ma} * {{MW{1'b0}}, r1_mb};
            end
        end
    end

    // ------------------------------------------------------------------
    // S3 combinational: normalise and round
    // ------------------------------------------------------------------
    logic                 w_msb, w_g, w_r, w_s, w_rup, w_carry, w_inexact;
    logic [MAN_W-1:0]     w_man;
    logic [MAN_W:0]       w_man_rnd;
    logic signed [EW-1:0] w_exp_fin;

    // Product is in [1,4): pick the kept field and guard/round/sticky bits
    always_comb begin
        w_msb = r2_prod[PW-1];
        w_man = MAN_ZERO;
        w_g   = 1'b0;
        w_r   = 1'b0;
        w_s   = 1'b0;
        if (w_msb) begin
            // Value >= 2: the extra right shift pushes bit 0 into sticky
            w_man = r2_prod[PW-2 -: MAN_W];
            w_g   = r2_prod[PW-2-MAN_W];
            w_r   = r2_prod[PW-3-MAN_W];
            w_s   = |r2_prod[PW-4-MAN_W:0];
        end else begin
            w_man = r2_prod[PW-3 -: MAN_W];
            w_g   = r2_prod[PW-3-MAN_W];
            w_r   = r2_prod[PW-4-MAN_W];
            w_s   = |r2_prod[PW-5-MAN_W:0];
        end
    end

    // Round to nearest-even; a carry out leaves the field at zero (1.0 x 2)
    always_comb begin
        w_rup     = w_g && (w_r || w_s || w_man[0]);
        w_man_rnd = {1'b0, w_man} + {{MAN_W{1'b0}}, w_rup};
        w_carry   = w_man_rnd[MAN_W];
        w_inexact = w_g || w_r || w_s;
        w_exp_fin = r2_exp + $signed({{(EW-1){1'b0}}, w_msb})
                           + $signed({{(EW-1){1'b0}}, w_carry});
    end

    // ------------------------------------------------------------------
    // S3 combinational: exception priority and packing
    // ------------------------------------------------------------------
    logic [EXP_W+MAN_W:0] w_res_prod;
    logic [3:0]           w_res_flags;

    // Special operands take priority over range checks on the computed exponent
    always_comb begin
        w_res_prod  = {r2_sign, EXP_ZERO, MAN_ZERO};
        w_res_flags = 4'b0000;
        if (r2_nan) begin
            w_res_prod  = {1'b0, EXP_ONES, MAN_QNAN};
            w_res_flags = 4'b1000;
        end else if (r2_inf) begin
            w_res_prod  = {r2_sign, EXP_ONES, MAN_ZERO};
            w_res_flags = 4'b0000;
        end else if (r2_zero) begin
            w_res_prod  = {r2_sign, EXP_ZERO, MAN_ZERO};
            w_res_flags = 4'b0000;
        end else if (w_exp_fin >= EXP_INF_S) begin
            w_res_prod  = {r2_sign, EXP_ONES, MAN_ZERO};
            w_res_flags = 4'b0101;
        end else if (w_exp_fin <= EXP_ZERO_S) begin
            w_res_prod  = {r2_sign, EXP_ZERO, MAN_ZERO};
            w_res_flags = 4'b0011;
        end else begin
            w_res_prod  = {r2_sign, w_exp_fin[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
            w_res_flags = {3'b000, w_inexact};
        end
    end

    // ------------------------------------------------------------------
    // S3 register: output holding register
    // ------------------------------------------------------------------
    logic [EXP_W+MAN_W:0] r3_product;
    logic [3:0]           r3_flags;

    // Stage 3: output register, holds while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r3_valid   <= 1'b0;
            r3_product <= {(EXP_W+MAN_W+1){1'b0}};
            r3_flags   <= 4'b0000;
        end else if (w_s3_load) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_product <= w_res_prod;
                r3_flags   <= w_res_flags;
            end
        end
    end

    assign product = r3_product;
    assign flags   = r3_flags;

endmodule

// File: tb/tb_vp_fp_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_vp_fp_mul_pipe -- self-checking bench for vp_fp_mul_pipe (bfloat16 params).
//
// Expected results come from a real-arithmetic reference: operands are
// decoded to their real values, multiplied exactly in double precision, and
// the double is rounded back to bfloat16 (nearest-even). A scoreboard queue
// holds expected {product, flags} in accept order. A negedge monitor pops
// the queue on every output handshake.
// ---------------------------------------------------------------------------
module tb_vp_fp_mul_pipe;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, product;
    logic [1:0]  prec_mode;
    logic [3:0]  flags;

    int          n_vec = 0;
    int          n_err = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;
    bit          rand_ready = 1'b0;

    // Directed cases: operands, mode, expected product and flags
    logic [15:0] d_a [14] = '{16'h3FC0, 16'h3FFF, 16'h3FFF, 16'h7F00, 16'h7F80, 16'h8000, 16'h0180,
                              16'h0001, 16'hFF80, 16'h7FC1, 16'h3FFF, 16'h3FFF, 16'h3F81, 16'h3F83};
    logic [15:0] d_b [14] = '{16'h4000, 16'h3FFF, 16'h3FFF, 16'h7F00, 16'h0000, 16'h3F80, 16'h0180,
                              16'h3F80, 16'h3F80, 16'h3F80, 16'h3FFF, 16'h3FFF, 16'h3FC0, 16'h3FC0};
    logic [1:0]  d_m [14] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0,
                              2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0};
    logic [15:0] d_p [14] = '{16'h4040, 16'h407E, 16'h4061, 16'h7F80, 16'h7FC0, 16'h8000, 16'h0000,
                              16'h0000, 16'hFF80, 16'h7FC0, 16'h407E, 16'h4078, 16'h3FC2, 16'h3FC4};
    logic [3:0]  d_f [14] = '{4'b0000, 4'b0001, 4'b0000, 4'b0101, 4'b1000, 4'b0000, 4'b0011,
                              4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};

    vp_fp_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .prec_mode (prec_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic real pow2(input int n);
        logic [10:0] be;
        be = 11'(n + 1023);
        return $bitstoreal({1'b0, be, 52'd0});
    endfunction

    // Reference: {product[15:0], flags[3:0]} for bfloat16 operands
    function automatic logic [19:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input logic [1:0] m);
        int          ex, ey, mx, my, tr, e, be, m7;
        logic        s;
        bit          zx, zy, ix, iy, nx, ny, inx;
        real         p;
        logic [63:0] bits;
        logic [44:0] rest, half;
        ex = int'(x[14:7]);
        ey = int'(y[14:7]);
        mx = int'(x[6:0]);
        my = int'(y[6:0]);
        s  = x[15] ^ y[15];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (mx == 0);
        iy = (ey == 255) && (my == 0);
        nx = (ex == 255) && (mx != 0);
        ny = (ey == 255) && (my != 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return {16'h7FC0, 4'b1000};
        if (ix || iy) return {s, 15'h7F80, 4'b0000};
        if (zx || zy) return {s, 15'h0000, 4'b0000};
        case (m)
            2'd1:    tr = 2;
            2'd2:    tr = 4;
            default: tr = 0;
        endcase
        mx = (mx >> tr) << tr;
        my = (my >> tr) << tr;
        p = (real'(128 + mx) / 128.0) * pow2(ex - 127) * (real'(128 + my) / 128.0) * pow2(ey - 127);
        bits = $realtobits(p);
        e    = int'(bits[62:52]) - 1023;
        m7   = int'(bits[51:45]);
        rest = bits[44:0];
        half = 45'd1 << 44;
        inx  = (rest != 45'd0);
        if ((rest > half) || ((rest == half) && (m7 % 2 == 1))) m7 = m7 + 1;
        if (m7 == 128) begin
            m7 = 0;
            e  = e + 1;
        end
        be = e + 127;
        if (be >= 255) return {s, 15'h7F80, 4'b0101};
        if (be <= 0) return {s, 15'h0000, 4'b0011};
        return {s, 8'(be), 7'(m7), 3'b000, inx};
    endfunction

    // Operand mix weighted toward normal numbers, with specials and extremes
    function automatic logic [15:0] rnd_op();
        int         sel;
        logic [7:0] e;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      e = 8'hFF;
        else if (sel == 1) e = 8'h00;
        else if (sel < 5)  e = 8'($urandom_range(0, 255));
        else               e = 8'($urandom_range(64, 190));
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    // Offer one pair until accepted (bounded), recording its expected result
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic [1:0] tm,
                        input logic [19:0] ex);
        bit acc;
        acc = 1'b0;
        a = ta;
        b = tb;
        prec_mode = tm;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(ex);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("stray_result", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("product", 32'(product), 32'(mon_e[19:4]));
                chk("flags", 32'(flags), 32'(mon_e[3:0]));
            end
        end
    end

    initial begin
        int          lat;
        int          idx;
        int          outs;
        logic [15:0] ta, tb;
        logic [1:0]  tm;
        logic [15:0] bp_a [6];
        logic [15:0] bp_b [6];
        logic [1:0]  bp_m [6];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        prec_mode = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // First directed case also measures accept-to-valid latency
        @(posedge clk);
        #1;
        a = d_a[0];
        b = d_b[0];
        prec_mode = d_m[0];
        in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back({d_p[0], d_f[0]});
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        drain();

        // Remaining directed cases
        for (int i = 1; i < 14; i++) send(d_a[i], d_b[i], d_m[i], {d_p[i], d_f[i]});
        drain();

        // Backpressure: out_ready low, offer 6 pairs, only 3 fit
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = rnd_op();
            bp_b[i] = rnd_op();
            bp_m[i] = 2'($urandom_range(0, 3));
        end
        out_ready = 1'b0;
        idx = 0;
        a = bp_a[0];
        b = bp_b[0];
        prec_mode = bp_m[0];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(ref_mul(bp_a[idx], bp_b[idx], bp_m[idx]));
                idx++;
            end
            if (c >= 3) begin
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_product", 32'(product), 32'(exp_q[0][19:4]));
                chk("bp_hold_flags", 32'(flags), 32'(exp_q[0][3:0]));
            end
            @(posedge clk);
            #1;
            a = bp_a[idx];
            b = bp_b[idx];
            prec_mode = bp_m[idx];
        end
        chk("bp_accepts", 32'(idx), 32'd3);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("bp_stream_valid", 32'(out_valid), 32'd1);
            if (in_ready === 1'b1 && idx < 6) begin
                exp_q.push_back(ref_mul(bp_a[idx], bp_b[idx], bp_m[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) begin
                a = bp_a[idx];
                b = bp_b[idx];
                prec_mode = bp_m[idx];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_total", 32'(idx), 32'd6);
        drain();

        // Reset with three operations in flight: nothing may emerge afterwards
        out_ready = 1'b0;
        a = 16'h3F80;
        b = 16'h4000;
        prec_mode = 2'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_fill_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_fill_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        outs = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) outs++;
        end
        chk("midrst_no_stale", 32'(outs), 32'd0);
        @(posedge clk);
        #1;

        // Random stream with random gaps, modes and downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ta = rnd_op();
            tb = rnd_op();
            tm = 2'($urandom_range(0, 3));
            send(ta, tb, tm, ref_mul(ta, tb, tm));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
